// File: rtl/risc_ctrl_seq_pkg.sv
// Shared header for the RISC control sequencer: state type, instruction
// type codes and branch condition codes.
package risc_ctrl_seq_pkg;

  // Instruction-cycle states; encodings are visible on Current_State.
  typedef enum logic [2:0] {
    RESET_ST  = 3'd0,
    FETCH     = 3'd1,
    READ_OPS  = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  // Instruction type field values.
  localparam logic [1:0] TYPE_CTRL    = 2'b00;  // control: call/ret/out
  localparam logic [1:0] TYPE_ALU     = 2'b01;  // ALU, register operands
  localparam logic [1:0] TYPE_ALU_IMM = 2'b10;  // ALU, immediate operand B
  localparam logic [1:0] TYPE_IMM     = 2'b11;  // immediate result path

  // Branch condition codes.
  localparam logic [7:0] COND_N      = 8'h00;
  localparam logic [7:0] COND_Z      = 8'h01;
  localparam logic [7:0] COND_C      = 8'h02;
  localparam logic [7:0] COND_ALWAYS = 8'h3F;

  // Types that go through the ALU and may need multi-cycle completion.
  function automatic logic is_alu_type(input logic [1:0] t);
    return (t == TYPE_ALU) || (t == TYPE_ALU_IMM);
  endfunction

endpackage

// File: rtl/risc_branch_eval.sv
// Combinational branch condition evaluation; shared with the PC unit.
module risc_branch_eval
  import risc_ctrl_seq_pkg::*;
(
  input  logic [7:0] i_cond,
  input  logic       i_inv,
  input  logic       i_neg,
  input  logic       i_zro,
  input  logic       i_carry,
  output logic       o_taken
);

  // Select the flag named by the condition code; inv complements it,
  // and turns "always" into "never". Unknown codes are never taken.
  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_N:      o_taken = i_neg ^ i_inv;
      COND_Z:      o_taken = i_zro ^ i_inv;
      COND_C:      o_taken = i_carry ^ i_inv;
      COND_ALWAYS: o_taken = ~i_inv;
      default:     o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/risc_ctrl_seq.sv
// Control sequencer: instruction-cycle FSM, datapath strobe decode,
// call-stack depth tracking with fault halt, retired-instruction counter.
module risc_ctrl_seq
  import risc_ctrl_seq_pkg::*;
#(
  parameter int unsigned INSTR_W         = 32,
  parameter int unsigned STACK_DEPTH     = 8,
  parameter int unsigned MULTI_CYCLE_ALU = 0,
  parameter int unsigned CNT_W           = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Crnt_Instrn,
  input  logic               Instr_Valid,
  input  logic               Alu_Done,
  input  logic               Out_Ready,
  input  logic               Neg_Flag,
  input  logic               Zro_Flag,
  input  logic               Carry_Flag,
  output logic [2:0]         Current_State,
  output logic               Latch_Instr,
  output logic               Rd_Oprnd_A,
  output logic               Rd_Oprnd_B,
  output logic               Latch_Flags,
  output logic               Latch_Result,
  output logic               Write_RegC,
  output logic               Reset_AluRegs,
  output logic               PushEnbl,
  output logic               PopEnbl,
  output logic               OUT_VALID,
  output logic               UseData_Imm_Or_RegB,
  output logic               UseData_Imm_Or_ALU,
  output logic               EndOfInstrn,
  output logic               Stack_Fault,
  output logic [CNT_W-1:0]   Instr_Count
);

  localparam int unsigned M       = INSTR_W - 1;
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  state_t             r_state;
  state_t             w_next;
  logic [DEPTH_W-1:0] r_depth;
  logic [CNT_W-1:0]   r_count;
  logic               r_fault;
  logic               r_use_regb;
  logic               r_use_alu;
  logic               r_end_instr;

  // Instruction fields, located relative to the MSB.
  logic [1:0] w_type;
  logic       w_call;
  logic       w_ret;
  logic       w_inv;
  logic       w_out;
  logic [7:0] w_cond;
  logic       w_unused_instr;

  assign w_type = Crnt_Instrn[M -: 2];
  assign w_call = Crnt_Instrn[M-3];
  assign w_ret  = Crnt_Instrn[M-4];
  assign w_inv  = Crnt_Instrn[M-6];
  assign w_out  = Crnt_Instrn[M-7];
  assign w_cond = Crnt_Instrn[M-8 -: 8];
  assign w_unused_instr = ^{Crnt_Instrn[M-2], Crnt_Instrn[M-5], Crnt_Instrn[M-16:0]};

  logic w_taken;

  risc_branch_eval u_branch_eval (
    .i_cond  (w_cond),
    .i_inv   (w_inv),
    .i_neg   (Neg_Flag),
    .i_zro   (Zro_Flag),
    .i_carry (Carry_Flag),
    .o_taken (w_taken)
  );

  logic w_alu_type;
  logic w_is_out;
  logic w_stall;
  logic w_exec_go;
  logic w_push_req;
  logic w_pop_req;
  logic w_underflow;
  logic w_overflow;
  logic w_fault;
  logic w_sel_active;
  logic w_sel_regb;
  logic w_sel_alu;

  assign w_alu_type = is_alu_type(w_type);
  assign w_is_out   = (w_type == TYPE_CTRL) && w_out;
  assign w_stall    = ((MULTI_CYCLE_ALU != 0) && w_alu_type && !Alu_Done)
                    || (w_is_out && !Out_Ready);
  assign w_exec_go  = (r_state == EXECUTE) && !w_stall;

  // Stack requests only count in the EXECUTE exit cycle.
  assign w_push_req = w_exec_go && (w_type == TYPE_CTRL) && w_call && w_taken;
  assign w_pop_req  = w_exec_go && (w_type == TYPE_CTRL) && w_ret;

  // Combined call+ret pops first, so it underflows at depth 0 but never
  // overflows; a lone push overflows only at full depth.
  assign w_underflow = w_pop_req && (r_depth == '0);
  assign w_overflow  = w_push_req && !w_pop_req && (r_depth == DEPTH_MAX);
  assign w_fault     = w_underflow || w_overflow;

  assign w_sel_active = (r_state == READ_OPS) || (r_state == EXECUTE)
                      || (r_state == WRITEBACK);
  assign w_sel_regb   = w_sel_active && (w_type == TYPE_ALU_IMM);
  assign w_sel_alu    = w_sel_active && (w_type == TYPE_IMM);

  // State register; Reset overrides every state including HALT.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= RESET_ST;
    else       r_state <= w_next;
  end

  // Next-state and combinational datapath strobes.
  always_comb begin
    w_next        = r_state;
    Latch_Instr   = 1'b0;
    Rd_Oprnd_A    = 1'b0;
    Rd_Oprnd_B    = 1'b0;
    Latch_Flags   = 1'b0;
    Latch_Result  = 1'b0;
    Write_RegC    = 1'b0;
    Reset_AluRegs = 1'b0;
    PushEnbl      = 1'b0;
    PopEnbl       = 1'b0;
    OUT_VALID     = 1'b0;
    case (r_state)
      RESET_ST: w_next = FETCH;
      FETCH: begin
        Reset_AluRegs = 1'b1;
        Latch_Instr   = Instr_Valid;
        if (Instr_Valid) w_next = READ_OPS;
      end
      READ_OPS: begin
        case (w_type)
          TYPE_CTRL: Rd_Oprnd_A = w_out;
          TYPE_IMM:  Rd_Oprnd_B = 1'b1;
          default: begin
            Rd_Oprnd_A = 1'b1;
            Rd_Oprnd_B = 1'b1;
          end
        endcase
        w_next = EXECUTE;
      end
      EXECUTE: begin
        OUT_VALID = w_is_out;
        if (w_fault) begin
          w_next = HALT;
        end else if (!w_stall) begin
          w_next       = WRITEBACK;
          Latch_Flags  = w_alu_type;
          Latch_Result = (w_type != TYPE_CTRL);
          PushEnbl     = w_push_req;
          PopEnbl      = w_pop_req;
        end
      end
      WRITEBACK: begin
        Write_RegC = (w_type != TYPE_CTRL);
        w_next     = FETCH;
      end
      HALT:    w_next = HALT;
      default: w_next = RESET_ST;
    endcase
  end

  // Call-stack depth: a faulting request leaves the depth untouched.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_depth <= '0;
    end else if (!w_fault) begin
      if (w_push_req && !w_pop_req)      r_depth <= r_depth + DEPTH_W'(1);
      else if (w_pop_req && !w_push_req) r_depth <= r_depth - DEPTH_W'(1);
    end
  end

  // Sticky stack fault flag.
  always_ff @(posedge Clk) begin
    if (Reset)        r_fault <= 1'b0;
    else if (w_fault) r_fault <= 1'b1;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge Clk) begin
    if (Reset)                       r_count <= '0;
    else if (r_state == WRITEBACK)   r_count <= r_count + CNT_W'(1);
  end

  // Registered mux selects and end-of-instruction marker.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_use_regb  <= 1'b0;
      r_use_alu   <= 1'b0;
      r_end_instr <= 1'b0;
    end else begin
      r_use_regb  <= w_sel_regb;
      r_use_alu   <= w_sel_alu;
      r_end_instr <= (r_state == WRITEBACK);
    end
  end

  assign Current_State       = r_state;
  assign UseData_Imm_Or_RegB = r_use_regb;
  assign UseData_Imm_Or_ALU  = r_use_alu;
  assign EndOfInstrn         = r_end_instr;
  assign Stack_Fault         = r_fault;
  assign Instr_Count         = r_count;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Scoreboard bench for risc_ctrl_seq (STACK_DEPTH=2, MULTI_CYCLE_ALU=1).
module tb_risc_ctrl_seq;

  logic        Clk;
  logic        Reset;
  logic [31:0] Crnt_Instrn;
  logic        Instr_Valid, Alu_Done, Out_Ready;
  logic        Neg_Flag, Zro_Flag, Carry_Flag;
  logic [2:0]  Current_State;
  logic        Latch_Instr, Rd_Oprnd_A, Rd_Oprnd_B, Latch_Flags, Latch_Result;
  logic        Write_RegC, Reset_AluRegs, PushEnbl, PopEnbl, OUT_VALID;
  logic        UseData_Imm_Or_RegB, UseData_Imm_Or_ALU, EndOfInstrn, Stack_Fault;
  logic [15:0] Instr_Count;

  risc_ctrl_seq #(
    .INSTR_W         (32),
    .STACK_DEPTH     (2),
    .MULTI_CYCLE_ALU (1),
    .CNT_W           (16)
  ) dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .Crnt_Instrn         (Crnt_Instrn),
    .Instr_Valid         (Instr_Valid),
    .Alu_Done            (Alu_Done),
    .Out_Ready           (Out_Ready),
    .Neg_Flag            (Neg_Flag),
    .Zro_Flag            (Zro_Flag),
    .Carry_Flag          (Carry_Flag),
    .Current_State       (Current_State),
    .Latch_Instr         (Latch_Instr),
    .Rd_Oprnd_A          (Rd_Oprnd_A),
    .Rd_Oprnd_B          (Rd_Oprnd_B),
    .Latch_Flags         (Latch_Flags),
    .Latch_Result        (Latch_Result),
    .Write_RegC          (Write_RegC),
    .Reset_AluRegs       (Reset_AluRegs),
    .PushEnbl            (PushEnbl),
    .PopEnbl             (PopEnbl),
    .OUT_VALID           (OUT_VALID),
    .UseData_Imm_Or_RegB (UseData_Imm_Or_RegB),
    .UseData_Imm_Or_ALU  (UseData_Imm_Or_ALU),
    .EndOfInstrn         (EndOfInstrn),
    .Stack_Fault         (Stack_Fault),
    .Instr_Count         (Instr_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Strobe masks, order: LI RA RB LF LR WC RAR PU PO OV
  localparam logic [9:0] NONE = 10'h000;
  localparam logic [9:0] LI   = 10'h200;
  localparam logic [9:0] RA   = 10'h100;
  localparam logic [9:0] RB   = 10'h080;
  localparam logic [9:0] LF   = 10'h040;
  localparam logic [9:0] LR   = 10'h020;
  localparam logic [9:0] WC   = 10'h010;
  localparam logic [9:0] RAR  = 10'h008;
  localparam logic [9:0] PU   = 10'h004;
  localparam logic [9:0] PO   = 10'h002;
  localparam logic [9:0] OV   = 10'h001;

  // One clock of stimulus plus its expected observation.
  typedef struct {
    logic [31:0] ins;
    logic [6:0]  ctl;  // {rst, iv, alu_done, out_ready, N, Z, C}
    logic [2:0]  st;
    logic [9:0]  sb;
    logic [2:0]  rg;   // {EndOfInstrn, UseB, UseALU}
    logic        sf;
    logic [15:0] cnt;
  } step_t;

  step_t       tbl[$];
  step_t       m_prev;
  logic [32:0] sbq[$];
  logic [32:0] e;
  int          n_tests;
  int          n_fail;

  function automatic logic [31:0] mk(input logic [1:0] t, input logic call, input logic ret,
                                     input logic inv, input logic out, input logic [7:0] cond);
    logic [31:0] v;
    v = 32'h0000_5A3C;
    v[31:30] = t;
    v[28]    = call;
    v[27]    = ret;
    v[25]    = inv;
    v[24]    = out;
    v[23:16] = cond;
    return v;
  endfunction

  function automatic logic [32:0] observed();
    return {Current_State, Latch_Instr, Rd_Oprnd_A, Rd_Oprnd_B, Latch_Flags, Latch_Result,
            Write_RegC, Reset_AluRegs, PushEnbl, PopEnbl, OUT_VALID,
            EndOfInstrn, UseData_Imm_Or_RegB, UseData_Imm_Or_ALU, Stack_Fault, Instr_Count};
  endfunction

  // Append a step; registered outputs, fault flag and counter follow from the
  // previous step's inputs and expected state.
  task automatic add(input logic [31:0] ins, input logic [6:0] ctl,
                     input logic [2:0] st, input logic [9:0] sb);
    step_t s;
    s.ins = ins; s.ctl = ctl; s.st = st; s.sb = sb;
    if (m_prev.ctl[6]) begin
      s.rg = 3'b000; s.sf = 1'b0; s.cnt = 16'd0;
    end else begin
      s.rg[2] = (m_prev.st == 3'd4);
      s.rg[1] = (m_prev.st inside {3'd2, 3'd3, 3'd4}) && (m_prev.ins[31:30] == 2'b10);
      s.rg[0] = (m_prev.st inside {3'd2, 3'd3, 3'd4}) && (m_prev.ins[31:30] == 2'b11);
      s.cnt   = m_prev.cnt + 16'(m_prev.st == 3'd4);
      s.sf    = m_prev.sf | ((m_prev.st == 3'd3) && (st == 3'd5));
    end
    tbl.push_back(s);
    m_prev = s;
  endtask

  task automatic drive(input step_t s);
    Reset       = s.ctl[6];
    Instr_Valid = s.ctl[5];
    Alu_Done    = s.ctl[4];
    Out_Ready   = s.ctl[3];
    {Neg_Flag, Zro_Flag, Carry_Flag} = s.ctl[2:0];
    Crnt_Instrn = s.ins;
  endtask

  task automatic test_reset();
    add(32'h0, 7'b1_0_0_0_000, 3'd0, NONE);
    add(32'h0, 7'b1_0_0_0_000, 3'd0, NONE);
    add(32'h0, 7'b0_0_0_0_000, 3'd0, NONE);
    foreach (tbl[i]) begin
      @(posedge Clk); #1; drive(tbl[i]); sbq.push_back({tbl[i].st, tbl[i].sb, tbl[i].rg, tbl[i].sf, tbl[i].cnt});
      @(negedge Clk); e = sbq.pop_front(); n_tests++;
      if (observed() !== e) begin n_fail++; $display("FAIL reset[%0d]: got %09h required %09h", i, observed(), e); end
    end
    tbl.delete();
  endtask

  task automatic test_basic();
    logic [31:0] i1;
    i1 = mk(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    add(i1, 7'b0_1_1_0_000, 3'd1, LI | RAR);
    add(i1, 7'b0_0_1_0_000, 3'd2, RA | RB);
    add(i1, 7'b0_0_1_0_000, 3'd3, LF | LR);
    add(i1, 7'b0_0_0_0_000, 3'd4, WC);
    add(i1, 7'b0_0_0_0_000, 3'd1, RAR);
    foreach (tbl[i]) begin
      @(posedge Clk); #1; drive(tbl[i]); sbq.push_back({tbl[i].st, tbl[i].sb, tbl[i].rg, tbl[i].sf, tbl[i].cnt});
      @(negedge Clk); e = sbq.pop_front(); n_tests++;
      if (observed() !== e) begin n_fail++; $display("FAIL basic[%0d]: got %09h required %09h", i, observed(), e); end
    end
    tbl.delete();
  endtask

  task automatic test_fetch_wait();
    logic [31:0] i2;
    i2 = mk(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) add(i2, 7'b0_0_0_0_000, 3'd1, RAR);
    add(i2, 7'b0_1_0_0_000, 3'd1, LI | RAR);
    add(i2, 7'b0_0_0_0_000, 3'd2, RA | RB);
    add(i2, 7'b0_0_1_0_000, 3'd3, LF | LR);
    add(i2, 7'b0_0_0_0_000, 3'd4, WC);
    add(i2, 7'b0_0_0_0_000, 3'd1, RAR);
    foreach (tbl[i]) begin
      @(posedge Clk); #1; drive(tbl[i]); sbq.push_back({tbl[i].st, tbl[i].sb, tbl[i].rg, tbl[i].sf, tbl[i].cnt});
      @(negedge Clk); e = sbq.pop_front(); n_tests++;
      if (observed() !== e) begin n_fail++; $display("FAIL fetch_wait[%0d]: got %09h required %09h", i, observed(), e); end
    end
    tbl.delete();
  endtask

  task automatic test_multicycle();
    logic [31:0] i1;
    i1 = mk(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    add(i1, 7'b0_1_1_0_000, 3'd1, LI | RAR);
    add(i1, 7'b0_0_1_0_000, 3'd2, RA | RB);
    for (int k = 0; k < 5; k++) add(i1, 7'b0_0_0_0_000, 3'd3, NONE);
    add(i1, 7'b0_0_1_0_000, 3'd3, LF | LR);
    add(i1, 7'b0_0_0_0_000, 3'd4, WC);
    add(i1, 7'b0_0_0_0_000, 3'd1, RAR);
    foreach (tbl[i]) begin
      @(posedge Clk); #1; drive(tbl[i]); sbq.push_back({tbl[i].st, tbl[i].sb, tbl[i].rg, tbl[i].sf, tbl[i].cnt});
      @(negedge Clk); e = sbq.pop_front(); n_tests++;
      if (observed() !== e) begin n_fail++; $display("FAIL multicycle[%0d]: got %09h required %09h", i, observed(), e); end
    end
    tbl.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] i3;
    i3 = mk(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 2; k++) begin
      add(i3, 7'b0_1_0_0_000, 3'd1, LI | RAR);
      add(i3, 7'b0_1_0_0_000, 3'd2, RB);
      add(i3, 7'b0_1_0_0_000, 3'd3, LR);
      add(i3, 7'b0_1_0_0_000, 3'd4, WC);
    end
    add(i3, 7'b0_0_0_0_000, 3'd1, RAR);
    foreach (tbl[i]) begin
      @(posedge Clk); #1; drive(tbl[i]); sbq.push_back({tbl[i].st, tbl[i].sb, tbl[i].rg, tbl[i].sf, tbl[i].cnt});
      @(negedge Clk); e = sbq.pop_front(); n_tests++;
      if (observed() !== e) begin n_fail++; $display("FAIL back_to_back[%0d]: got %09h required %09h", i, observed(), e); end
    end
    tbl.delete();
  endtask

  task automatic test_stack_overflow();
    logic [31:0] ia, ic, id, ie;
    ia = mk(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02);  // call if !C
    ic = mk(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05);  // unknown code: never
    id = mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);  // call if N
    ie = mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3F);  // call always
    add(ia, 7'b1_0_0_0_000, 3'd1, RAR);
    add(ia, 7'b0_0_0_0_000, 3'd0, NONE);
    // !C with C=0 (N,Z set as decoys): push, depth 1
    add(ia, 7'b0_1_0_0_110, 3'd1, LI | RAR);
    add(ia, 7'b0_0_0_0_110, 3'd2, NONE);
    add(ia, 7'b0_0_0_0_110, 3'd3, PU);
    add(ia, 7'b0_0_0_0_110, 3'd4, NONE);
    // !C with C=1: not taken
    add(ia, 7'b0_1_0_0_001, 3'd1, LI | RAR);
    add(ia, 7'b0_0_0_0_001, 3'd2, NONE);
    add(ia, 7'b0_0_0_0_001, 3'd3, NONE);
    add(ia, 7'b0_0_0_0_001, 3'd4, NONE);
    // never
    add(ic, 7'b0_1_0_0_111, 3'd1, LI | RAR);
    add(ic, 7'b0_0_0_0_111, 3'd2, NONE);
    add(ic, 7'b0_0_0_0_111, 3'd3, NONE);
    add(ic, 7'b0_0_0_0_111, 3'd4, NONE);
    // N with N=1: push, depth 2
    add(id, 7'b0_1_0_0_100, 3'd1, LI | RAR);
    add(id, 7'b0_0_0_0_100, 3'd2, NONE);
    add(id, 7'b0_0_0_0_100, 3'd3, PU);
    add(id, 7'b0_0_0_0_100, 3'd4, NONE);
    // always at full depth: suppressed push, fault, halt
    add(ie, 7'b0_1_0_0_000, 3'd1, LI | RAR);
    add(ie, 7'b0_0_0_0_000, 3'd2, NONE);
    add(ie, 7'b0_0_0_0_000, 3'd3, NONE);
    add(ie, 7'b0_1_1_1_000, 3'd5, NONE);
    add(ie, 7'b0_1_1_1_000, 3'd5, NONE);
    foreach (tbl[i]) begin
      @(posedge Clk); #1; drive(tbl[i]); sbq.push_back({tbl[i].st, tbl[i].sb, tbl[i].rg, tbl[i].sf, tbl[i].cnt});
      @(negedge Clk); e = sbq.pop_front(); n_tests++;
      if (observed() !== e) begin n_fail++; $display("FAIL stack_overflow[%0d]: got %09h required %09h", i, observed(), e); end
    end
    tbl.delete();
  endtask

  task automatic test_stack_underflow();
    logic [31:0] ifa, ig, ih, ir;
    ifa = mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3F);  // call always
    ig  = mk(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3F);  // inverted always: never
    ih  = mk(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3F);  // call+ret
    ir  = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);  // ret
    add(ifa, 7'b1_0_0_0_000, 3'd5, NONE);
    add(ifa, 7'b0_0_0_0_000, 3'd0, NONE);
    add(ifa, 7'b0_1_0_0_000, 3'd1, LI | RAR);
    add(ifa, 7'b0_0_0_0_000, 3'd2, NONE);
    add(ifa, 7'b0_0_0_0_000, 3'd3, PU);
    add(ifa, 7'b0_0_0_0_000, 3'd4, NONE);
    add(ig,  7'b0_1_0_0_000, 3'd1, LI | RAR);
    add(ig,  7'b0_0_0_0_000, 3'd2, NONE);
    add(ig,  7'b0_0_0_0_000, 3'd3, NONE);
    add(ig,  7'b0_0_0_0_000, 3'd4, NONE);
    add(ih,  7'b0_1_0_0_000, 3'd1, LI | RAR);
    add(ih,  7'b0_0_0_0_000, 3'd2, NONE);
    add(ih,  7'b0_0_0_0_000, 3'd3, PU | PO);
    add(ih,  7'b0_0_0_0_000, 3'd4, NONE);
    add(ir,  7'b0_1_0_0_000, 3'd1, LI | RAR);
    add(ir,  7'b0_0_0_0_000, 3'd2, NONE);
    add(ir,  7'b0_0_0_0_000, 3'd3, PO);
    add(ir,  7'b0_0_0_0_000, 3'd4, NONE);
    add(ir,  7'b0_1_0_0_000, 3'd1, LI | RAR);
    add(ir,  7'b0_0_0_0_000, 3'd2, NONE);
    add(ir,  7'b0_0_0_0_000, 3'd3, NONE);
    add(ir,  7'b0_0_0_0_000, 3'd5, NONE);
    foreach (tbl[i]) begin
      @(posedge Clk); #1; drive(tbl[i]); sbq.push_back({tbl[i].st, tbl[i].sb, tbl[i].rg, tbl[i].sf, tbl[i].cnt});
      @(negedge Clk); e = sbq.pop_front(); n_tests++;
      if (observed() !== e) begin n_fail++; $display("FAIL stack_underflow[%0d]: got %09h required %09h", i, observed(), e); end
    end
    tbl.delete();
  endtask

  task automatic test_out_stall();
    logic [31:0] io;
    io = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    add(io, 7'b1_0_0_0_000, 3'd5, NONE);
    add(io, 7'b0_0_0_0_000, 3'd0, NONE);
    add(io, 7'b0_1_0_0_000, 3'd1, LI | RAR);
    add(io, 7'b0_0_0_0_000, 3'd2, RA);
    add(io, 7'b0_0_0_0_000, 3'd3, OV);
    add(io, 7'b0_0_0_0_000, 3'd3, OV);
    add(io, 7'b0_0_0_1_000, 3'd3, OV);
    add(io, 7'b0_0_0_0_000, 3'd4, NONE);
    add(io, 7'b0_1_0_1_000, 3'd1, LI | RAR);
    add(io, 7'b0_0_0_1_000, 3'd2, RA);
    add(io, 7'b0_0_0_0_000, 3'd3, OV);
    add(io, 7'b1_0_0_0_000, 3'd3, OV);
    add(io, 7'b0_0_0_0_000, 3'd0, NONE);
    add(io, 7'b0_0_0_0_000, 3'd1, RAR);
    foreach (tbl[i]) begin
      @(posedge Clk); #1; drive(tbl[i]); sbq.push_back({tbl[i].st, tbl[i].sb, tbl[i].rg, tbl[i].sf, tbl[i].cnt});
      @(negedge Clk); e = sbq.pop_front(); n_tests++;
      if (observed() !== e) begin n_fail++; $display("FAIL out_stall[%0d]: got %09h required %09h", i, observed(), e); end
    end
    tbl.delete();
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    Reset       = 1'b1;
    Crnt_Instrn = 32'h0;
    Instr_Valid = 1'b0;
    Alu_Done    = 1'b0;
    Out_Ready   = 1'b0;
    Neg_Flag    = 1'b0;
    Zro_Flag    = 1'b0;
    Carry_Flag  = 1'b0;
    m_prev      = '{ins: 32'h0, ctl: 7'b1_0_0_0_000, st: 3'd0, sb: 10'h0, rg: 3'b0, sf: 1'b0, cnt: 16'd0};
    test_reset();
    test_basic();
    test_fetch_wait();
    test_multicycle();
    test_back_to_back();
    test_stack_overflow();
    test_stack_underflow();
    test_out_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
